// File: rtl/shell_cmd_parser_if.sv
// shell_cmd_parser_if: byte streams to/from the UART and the parsed command handed to the dispatcher.
interface shell_cmd_parser_if;
    logic        i_rx_dv;
    logic [7:0]  i_rx_byte;
    logic        o_tx_dv;
    logic [7:0]  o_tx_byte;
    logic        i_tx_active;
    logic        o_busy;
    logic        o_cmd_valid;
    logic        o_cmd_err;
    logic [7:0]  o_cmd;
    logic [1:0]  o_argc;
    logic [15:0] o_arg0;
    logic [15:0] o_arg1;
    modport master (
        output i_rx_dv, i_rx_byte, i_tx_active,
        input  o_tx_dv, o_tx_byte, o_busy, o_cmd_valid, o_cmd_err, o_cmd, o_argc, o_arg0, o_arg1
    );
    modport slave (
        input  i_rx_dv, i_rx_byte, i_tx_active,
        output o_tx_dv, o_tx_byte, o_busy, o_cmd_valid, o_cmd_err, o_cmd, o_argc, o_arg0, o_arg1
    );
endinterface

// File: rtl/shell_cmd_parser.sv
// shell_cmd_parser: assembles an echoed, editable input line and parses it into a command letter
// plus up to two hex arguments, one buffer character per cycle.
module shell_cmd_parser #(
    parameter int MAX_LEN    = 10,
    parameter int ARG_DIGITS = 4
) (
    input  logic               CLK,
    input  logic               RST,
    shell_cmd_parser_if.slave  io_bus
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int DW = $clog2(ARG_DIGITS + 1);
    typedef enum logic [1:0] {COLLECT, PARSE, EMIT} state_t;
    typedef enum logic [1:0] {P_CMD, P_SEP, P_GAP, P_ARG} phase_t;
    state_t        r_state;
    phase_t        r_ph;
    logic [7:0]    r_buf [MAX_LEN];
    logic [LW-1:0] r_len, r_idx;
    logic          r_ovf, r_err, r_have, r_pend;
    logic [7:0]    r_pend_byte, r_cmd_tmp, r_cmd;
    logic [DW-1:0] r_ndig;
    logic [1:0]    r_ntok, r_argc;
    logic [15:0]   r_a0, r_a1, r_arg0, r_arg1;
    logic          r_cmd_valid, r_cmd_err;
    logic [7:0]    w_b, w_c, w_lc;
    logic [3:0]    w_nib;
    logic          w_rx, w_is_bs, w_is_prt, w_echo_bs, w_echo_chr, w_send;
    logic          w_sp, w_letter, w_digit, w_hex, w_last, w_ok;
    logic          w_perr, w_start, w_shift;
    phase_t        w_ph_n;
    assign w_b        = io_bus.i_rx_byte;
    assign w_rx       = r_state == COLLECT && io_bus.i_rx_dv;
    assign w_is_bs    = w_b == 8'h08 || w_b == 8'h7F;
    assign w_is_prt   = w_b >= 8'h20 && w_b <= 8'h7E;
    assign w_echo_bs  = w_rx && w_is_bs && r_len != '0;
    assign w_echo_chr = w_rx && w_is_prt && r_len < LW'(MAX_LEN);
    assign w_send     = r_pend && !io_bus.i_tx_active;
    // Setting bit 5 folds 'A'..'Z' onto 'a'..'z' without moving any other char into that range.
    assign w_c      = r_buf[r_idx];
    assign w_lc     = w_c | 8'h20;
    assign w_sp     = w_c == 8'h20;
    assign w_letter = w_lc >= "a" && w_lc <= "z";
    assign w_digit  = w_c >= "0" && w_c <= "9";
    assign w_hex    = w_digit || (w_lc >= "a" && w_lc <= "f");
    assign w_nib    = w_digit ? w_c[3:0] : w_lc[3:0] + 4'd9;
    assign w_last   = r_idx == r_len - LW'(1);
    assign w_ok     = !r_ovf && !r_err && r_have;
    always_comb begin
        w_ph_n  = r_ph;
        w_perr  = 1'b0;
        w_start = 1'b0;
        w_shift = 1'b0;
        case (r_ph)
            P_CMD: if (!w_sp) begin
                w_perr = !w_letter;
                w_ph_n = P_SEP;
            end
            P_SEP: begin
                w_perr = !w_sp;
                w_ph_n = P_GAP;
            end
            P_GAP: if (!w_sp) begin
                w_perr  = !w_hex || r_ntok == 2'd2;
                w_start = 1'b1;
                w_ph_n  = P_ARG;
            end
            default: if (w_sp) w_ph_n = P_GAP;
            else begin
                w_perr  = !w_hex || r_ndig == DW'(ARG_DIGITS);
                w_shift = 1'b1;
            end
        endcase
    end
    always_ff @(posedge CLK) if (w_echo_chr) r_buf[r_len] <= w_b;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= COLLECT;
            r_ph        <= P_CMD;
            r_len       <= '0;
            r_idx       <= '0;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
            r_have      <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_byte <= '0;
            r_cmd_tmp   <= '0;
            r_ndig      <= '0;
            r_ntok      <= '0;
            r_a0        <= '0;
            r_a1        <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_cmd       <= '0;
            r_argc      <= '0;
            r_arg0      <= '0;
            r_arg1      <= '0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_cmd_err   <= 1'b0;
            if (w_echo_bs || w_echo_chr) begin
                r_pend      <= 1'b1;
                r_pend_byte <= w_echo_bs ? 8'h08 : w_b;
            end else if (w_send) r_pend <= 1'b0;
            case (r_state)
                COLLECT: if (io_bus.i_rx_dv) begin
                    if (w_b == 8'h0D) begin
                        r_state <= r_len == '0 ? EMIT : PARSE;
                        r_idx   <= '0;
                        r_ph    <= P_CMD;
                        r_err   <= 1'b0;
                        r_have  <= 1'b0;
                        r_ntok  <= '0;
                        r_ndig  <= '0;
                        r_a0    <= '0;
                        r_a1    <= '0;
                    end else if (w_echo_bs) r_len <= r_len - LW'(1);
                    else if (w_echo_chr) r_len <= r_len + LW'(1);
                    else if (w_is_prt) r_ovf <= 1'b1;
                end
                PARSE: begin
                    r_idx <= r_idx + LW'(1);
                    r_ph  <= w_ph_n;
                    r_err <= r_err | w_perr;
                    if (r_ph == P_CMD && !w_sp) begin
                        r_have    <= 1'b1;
                        r_cmd_tmp <= w_lc;
                    end
                    if (w_start) begin
                        r_ntok <= r_ntok + 2'd1;
                        r_ndig <= DW'(1);
                        if (r_ntok == 2'd0) r_a0 <= {12'd0, w_nib};
                        else r_a1 <= {12'd0, w_nib};
                    end
                    if (w_shift) begin
                        r_ndig <= r_ndig + DW'(1);
                        if (r_ntok == 2'd1) r_a0 <= {r_a0[11:0], w_nib};
                        else r_a1 <= {r_a1[11:0], w_nib};
                    end
                    if (w_last) r_state <= EMIT;
                end
                default: begin
                    r_cmd_err   <= r_ovf | r_err;
                    r_cmd_valid <= w_ok;
                    if (w_ok) begin
                        r_cmd  <= r_cmd_tmp;
                        r_argc <= r_ntok;
                        r_arg0 <= r_a0;
                        r_arg1 <= r_a1;
                    end
                    r_len   <= '0;
                    r_ovf   <= 1'b0;
                    r_state <= COLLECT;
                end
            endcase
        end
    end
    assign io_bus.o_tx_dv     = w_send;
    assign io_bus.o_tx_byte   = r_pend_byte;
    assign io_bus.o_busy      = r_state != COLLECT;
    assign io_bus.o_cmd_valid = r_cmd_valid;
    assign io_bus.o_cmd_err   = r_cmd_err;
    assign io_bus.o_cmd       = r_cmd;
    assign io_bus.o_argc      = r_argc;
    assign io_bus.o_arg0      = r_arg0;
    assign io_bus.o_arg1      = r_arg1;
endmodule

// File: tb/tb_shell_cmd_parser.sv
// tb_shell_cmd_parser: directed and random lines checked against a string-level tokenizer model
// of line editing, echo and command parsing.
module tb_shell_cmd_parser;
    localparam int MAX_LEN = 10;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int checks = 0;
    int errors = 0;
    byte unsigned echo_q[$];
    byte unsigned lq[$];
    logic [7:0]  exp_cmd  = '0;
    logic [1:0]  exp_argc = '0;
    logic [15:0] exp_a0   = '0;
    logic [15:0] exp_a1   = '0;
    shell_cmd_parser_if bus ();
    shell_cmd_parser #(.MAX_LEN(MAX_LEN), .ARG_DIGITS(4)) dut (.CLK(CLK), .RST(RST), .io_bus(bus.slave));
    always #5 CLK = ~CLK;
    always @(negedge CLK) if (bus.o_tx_dv) echo_q.push_back(bus.o_tx_byte);
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic int hexval(input byte unsigned c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "a" && c <= "f") return int'(c) - 87;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        return -1;
    endfunction
    task automatic put(input string s);
        for (int i = 0; i < s.len(); i++) lq.push_back(s[i]);
    endtask
    // Reference: edit the line as a queue, split on spaces, then judge the token list.
    task automatic model(output byte unsigned echo[$], output int kind, output int len);
        byte unsigned b[$];
        string toks[$];
        string t, s;
        bit bad;
        byte unsigned c;
        int args[2];
        int hv;
        echo = {};
        bad = 1'b0;
        t = "";
        foreach (lq[i]) begin
            if (lq[i] == 8'h08 || lq[i] == 8'h7F) begin
                if (b.size() > 0) begin
                    void'(b.pop_back());
                    echo.push_back(8'h08);
                end
            end else if (lq[i] >= 8'h20 && lq[i] <= 8'h7E) begin
                if (b.size() < MAX_LEN) begin
                    b.push_back(lq[i]);
                    echo.push_back(lq[i]);
                end else bad = 1'b1;
            end
        end
        len = b.size();
        foreach (b[i]) begin
            if (b[i] == 8'h20) begin
                if (t.len() > 0) toks.push_back(t);
                t = "";
            end else t = $sformatf("%s%c", t, b[i]);
        end
        if (t.len() > 0) toks.push_back(t);
        if (toks.size() == 0) begin
            kind = bad ? 2 : 0;
            return;
        end
        s = toks[0];
        c = s[0];
        if (c >= "A" && c <= "Z") c = c + 8'd32;
        if (s.len() != 1 || !(c >= "a" && c <= "z")) bad = 1'b1;
        if (toks.size() > 3) bad = 1'b1;
        args[0] = 0;
        args[1] = 0;
        for (int k = 1; k < toks.size() && k < 3; k++) begin
            s = toks[k];
            if (s.len() > 4) bad = 1'b1;
            for (int j = 0; j < s.len(); j++) begin
                hv = hexval(s[j]);
                if (hv < 0) bad = 1'b1;
                else args[k-1] = args[k-1] * 16 + hv;
            end
        end
        kind = bad ? 2 : 1;
        if (!bad) begin
            exp_cmd  = c;
            exp_argc = 2'(toks.size() - 1);
            exp_a0   = 16'(args[0]);
            exp_a1   = 16'(args[1]);
        end
    endtask
    task automatic send_byte(input byte unsigned b);
        @(posedge CLK); #1;
        bus.i_rx_dv   = 1'b1;
        bus.i_rx_byte = b;
        @(posedge CLK); #1;
        bus.i_rx_dv   = 1'b0;
    endtask
    task automatic run_line(input string tag, input bit hold, input bit inject);
        byte unsigned exp_echo[$];
        byte unsigned last;
        int kind, len, lat, nstr, obs;
        bit sv, se;
        model(exp_echo, kind, len);
        echo_q = {};
        if (hold) begin
            @(posedge CLK); #1;
            bus.i_tx_active = 1'b1;
        end
        foreach (lq[i]) send_byte(lq[i]);
        if (hold) begin
            @(posedge CLK); #1;
            bus.i_tx_active = 1'b0;
            repeat (2) @(posedge CLK);
            #1;
            if (exp_echo.size() > 0) begin
                last = exp_echo[exp_echo.size()-1];
                exp_echo = {};
                exp_echo.push_back(last);
            end
        end
        send_byte(8'h0D);
        lat = -1;
        nstr = 0;
        sv = 1'b0;
        se = 1'b0;
        for (int k = 1; k <= MAX_LEN + 4; k++) begin
            @(negedge CLK);
            if (k == 1) begin
                chk({tag, " busy"}, 32'(bus.o_busy), 32'd1);
                if (inject) begin
                    bus.i_rx_dv   = 1'b1;
                    bus.i_rx_byte = "q";
                end
            end
            if (k == 2) bus.i_rx_dv = 1'b0;
            if (bus.o_cmd_valid || bus.o_cmd_err) begin
                nstr++;
                if (lat < 0) lat = k - 1;
                sv |= bus.o_cmd_valid;
                se |= bus.o_cmd_err;
            end
        end
        obs = nstr == 0 ? 0 : (sv && !se) ? 1 : (se && !sv) ? 2 : 3;
        chk({tag, " kind"}, 32'(obs), 32'(kind));
        if (kind != 0) begin
            chk({tag, " latency"}, 32'(lat), 32'(len + 1));
            chk({tag, " pulses"}, 32'(nstr), 32'd1);
        end
        chk({tag, " echo count"}, 32'(echo_q.size()), 32'(exp_echo.size()));
        for (int i = 0; i < exp_echo.size() && i < echo_q.size(); i++)
            chk($sformatf("%s echo%0d", tag, i), 32'(echo_q[i]), 32'(exp_echo[i]));
        chk({tag, " cmd/argc"}, {22'd0, bus.o_cmd, bus.o_argc}, {22'd0, exp_cmd, exp_argc});
        chk({tag, " args"}, {bus.o_arg0, bus.o_arg1}, {exp_a0, exp_a1});
    endtask
    initial begin
        string letters, hexs, pool;
        int r;
        letters = "gdwrxzGDWR";
        hexs = "0123456789abcdefABCDEF";
        pool = "gGdD rRwW 0123456789aAfFzZ-!";
        bus.i_rx_dv = 1'b0;
        bus.i_rx_byte = '0;
        bus.i_tx_active = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset ctl", {10'd0, bus.o_tx_dv, bus.o_tx_byte, bus.o_busy, bus.o_cmd_valid, bus.o_cmd_err, bus.o_cmd, bus.o_argc}, 32'd0);
        chk("reset args", {bus.o_arg0, bus.o_arg1}, 32'd0);
        RST = 1'b0;
        lq = {}; put("g"); run_line("g", 1'b0, 1'b0);
        lq = {}; put("d 0000 1111"); run_line("overflow", 1'b0, 1'b0);
        lq = {}; put("D 00 1F"); run_line("D 00 1F", 1'b0, 1'b1);
        lq = {}; put("w 12g4"); run_line("nonhex", 1'b0, 1'b0);
        lq = {}; put("w 12345"); run_line("5 digits", 1'b0, 1'b0);
        lq = {}; put("x"); lq.push_back(8'h08); lq.push_back(8'h08); put("r  AB"); run_line("backspace", 1'b0, 1'b0);
        lq = {}; run_line("empty", 1'b0, 1'b1);
        lq = {}; put("   "); run_line("spaces", 1'b0, 1'b0);
        lq = {}; put("g"); run_line("g again", 1'b0, 1'b0);
        lq = {}; put("r 1 2 3"); run_line("3 args", 1'b0, 1'b0);
        lq = {}; put("W FFFF 0"); run_line("max arg", 1'b0, 1'b0);
        lq = {}; put("d 12");
        foreach (lq[i]) send_byte(lq[i]);
        @(negedge CLK); #2;
        RST = 1'b1;
        #1;
        chk("async rst ctl", {10'd0, bus.o_tx_dv, bus.o_tx_byte, bus.o_busy, bus.o_cmd_valid, bus.o_cmd_err, bus.o_cmd, bus.o_argc}, 32'd0);
        chk("async rst args", {bus.o_arg0, bus.o_arg1}, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        exp_cmd = '0;
        exp_argc = '0;
        exp_a0 = '0;
        exp_a1 = '0;
        lq = {}; put("g"); run_line("post reset", 1'b0, 1'b0);
        lq = {}; put("g "); run_line("tx hold", 1'b1, 1'b0);
        for (int n = 0; n < 40; n++) begin
            lq = {};
            if ($urandom_range(1, 0) == 1) begin
                repeat ($urandom_range(2, 0)) lq.push_back(8'h20);
                lq.push_back(letters[$urandom_range(letters.len() - 1, 0)]);
                repeat ($urandom_range(3, 0)) begin
                    repeat ($urandom_range(2, 1)) lq.push_back(8'h20);
                    repeat ($urandom_range(5, 1)) lq.push_back(hexs[$urandom_range(hexs.len() - 1, 0)]);
                end
                if ($urandom_range(3, 0) == 0) lq.push_back(8'h20);
            end else begin
                repeat ($urandom_range(13, 0)) begin
                    r = $urandom_range(9, 0);
                    lq.push_back(r == 0 ? 8'h08 : r == 1 ? 8'h01 : r == 2 ? 8'h7F : pool[$urandom_range(pool.len() - 1, 0)]);
                end
            end
            run_line($sformatf("rnd%0d", n), $urandom_range(5, 0) == 0, $urandom_range(3, 0) == 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/shell_cmd_parser.md
Name: shell_cmd_parser

Overview:
Line assembler and command parser between the UART receiver and the shell command dispatcher. It collects received bytes into a line buffer, echoes them back, and handles backspace. On carriage return it parses the line into a command letter plus up to two 16-bit hex arguments. It issues a one-cycle command strobe (or error strobe) that the dispatcher consumes to drive memory read/write/go operations on the hack CPU.

Parameters:
MAX_LEN, 10, line buffer depth in characters (excluding CR)
ARG_DIGITS, 4, maximum hex digits per argument

Ports:
CLK  in  1  system clock
RST  in  1  reset; asynchronous, active-high
i_rx_dv  in  1  one-cycle strobe: i_rx_byte valid
i_rx_byte  in  8  received byte
o_tx_dv  out  1  one-cycle echo strobe to UART TX
o_tx_byte  out  8  echo byte, valid with o_tx_dv
i_tx_active  in  1  UART TX busy; no o_tx_dv while high
o_busy  out  1  high in PARSE/EMIT; received bytes dropped
o_cmd_valid  out  1  one-cycle strobe: parsed command valid
o_cmd_err  out  1  one-cycle strobe: line rejected
o_cmd  out  8  command letter, lowercase ASCII
o_argc  out  2  number of arguments parsed (0..2)
o_arg0  out  16  first argument
o_arg1  out  16  second argument

Behaviour:
- Reset (async, any state, including mid-line/mid-parse): state=COLLECT, len=0, overflow=0, echo pending=0. All outputs 0.
- States: COLLECT, PARSE, EMIT.
- COLLECT, on i_rx_dv:
  - 0x0D: go to PARSE with index=0. No echo.
  - 0x08 or 0x7F: if len>0, len-=1 and echo 0x08; if len=0, ignore.
  - 0x20..0x7E: if len<MAX_LEN, store at buf[len], len+=1, echo the byte. Otherwise set overflow and do not echo.
  - Any other byte: ignored.
- Echo: single pending register. o_tx_dv pulses on the first cycle with pending=1 and i_tx_active=0, then pending clears. A new echo while pending overwrites the pending byte (oldest lost).
- PARSE: one buffer character per cycle, index 0..len-1. Token rules:
  - Leading spaces are skipped.
  - First non-space char is the command: 'a'..'z' stored as-is, 'A'..'Z' converted to lowercase, anything else is an error.
  - Command must be followed by a space or end of line; otherwise error.
  - Subsequent space-separated tokens are hex arguments: 0-9, a-f, A-F, accumulated as arg = {arg[11:0], nibble}.
  - More than ARG_DIGITS digits in a token, a non-hex char, or a third token is an error.
  - Multiple spaces between tokens are allowed.
  - The error flag is sticky for the rest of the line.
- EMIT: entered after the last character (or immediately if len=0), held one cycle.
  - overflow or error: o_cmd_err=1.
  - No command found (empty or all-space line): neither strobe.
  - Otherwise: o_cmd_valid=1 with o_cmd, o_argc, o_arg0, o_arg1 updated. Unused args read 0.
  - Field outputs hold until the next o_cmd_valid. On error they are unchanged.
  - Then len=0, overflow=0, state=COLLECT.
- Latency: strobe is high exactly len+1 cycles after the clock edge that samples CR.
- i_rx_dv during PARSE/EMIT (o_busy=1) is dropped, with no echo.

Test Plan:
- "g" then 0x0D: echo 0x67. o_cmd_valid pulse 2 cycles after CR edge; o_cmd=0x67, o_argc=0, o_arg0=0, o_arg1=0.
- "d 0000 1111" + CR: 11 chars exceeds MAX_LEN=10, so 10 echoes, then o_cmd_err=1, o_cmd_valid=0. Repeat "D 00 1F" + CR: o_cmd=0x64, o_argc=2, o_arg0=0x0000, o_arg1=0x001F.
- "w 12g4" + CR: o_cmd_err=1; o_cmd/o_arg fields keep the previous values. "w 12345" + CR: o_cmd_err (5 digits).
- "x", 0x08, 0x08, "r  AB" + CR: echoes 0x78, 0x08 (second BS ignored), then 0x72, 0x20, 0x20, 0x41, 0x42. Result o_cmd=0x72, o_argc=1, o_arg0=0x00AB.
- CR alone, and "   " + CR: no strobe of either kind. The next "g" + CR still parses correctly.
- "d 12" without CR, assert RST for 1 cycle mid-clock: outputs 0 immediately. Subsequent "g" + CR yields o_cmd=0x67, o_argc=0 (no residue). Hold i_tx_active=1 through two echoes: only the last byte is sent once i_tx_active falls.
